uart_conf_rx: RTL and testbench

Parametrised UART configuration receiver for the DRSSTC controller. It receives 8-bit serial bytes, assembles them into framed configuration packets (sync byte, N multi-byte parameters, checksum), and updates the parameter bank atomically only when the whole packet is valid. It replaces the fixed 9600-baud shift-register receiver. It adds configurable baud, parity, parameter width and count, checksum and idle-timeout checks, and error reporting.

---
 rtl/uart_conf_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_conf_rx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_conf_rx.sv
// UART configuration receiver: a bit engine recovers bytes from the serial line and a
// packet decoder commits the parameter bank only when sync, payload and checksum are all good.
module uart_conf_rx #(
  parameter int              CLK_HZ       = 50_000_000,
  parameter int              BAUD         = 9600,
  parameter int              PAR_CNT      = 4,
  parameter int              PAR_W        = 16,
  parameter int              PARITY       = 0,
  parameter logic [7:0]      SYNC_BYTE    = 8'hA5,
  parameter int              TIMEOUT_BITS = 20,
  parameter logic [PAR_W-1:0] PAR_RST     = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_data,
  output logic [PAR_CNT*PAR_W-1:0] par_out,
  output logic                     conf_valid,
  output logic                     conf_err,
  output logic [7:0]               rx_byte,
  output logic                     rx_strobe,
  output logic [1:0]               state
);

  localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BYTES   = (PAR_W + 7) / 8;
  localparam int CNT_W   = $clog2(DIV);
  localparam int TO_CLKS = TIMEOUT_BITS * DIV;
  localparam int TO_W    = $clog2(TO_CLKS + 1);
  localparam int PI_W    = (PAR_CNT > 1) ? $clog2(PAR_CNT) : 1;
  localparam int SI_W    = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CLKS - 1);
  localparam logic [PI_W-1:0]  LAST_PAR = PI_W'(PAR_CNT - 1);
  localparam logic [SI_W-1:0]  LAST_SUB = SI_W'(BYTES - 1);

  typedef enum logic [2:0] {B_IDLE, B_START, B_BITS, B_PAR, B_STOP} bit_state_t;
  typedef enum logic [1:0] {HUNT = 2'b00, DATA = 2'b01, CSUM = 2'b10} pkt_state_t;

  logic [1:0] sync_q;
  logic       rx_s;
  logic       rx_prev;

  bit_state_t       bstate, bstate_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shreg, shreg_d;
  logic             par_bad, par_bad_d;
  logic             stop_hit;
  logic             frame_ok;
  logic             byte_err;

  pkt_state_t       pstate, pstate_d;
  logic [7:0]       sum;
  logic [PI_W-1:0]  par_idx;
  logic [SI_W-1:0]  sub_idx;
  logic [TO_W-1:0]  timer;
  logic [PAR_W-1:0] shadow [PAR_CNT];
  logic             start_pkt, take_data, commit, abort, timed_out;

  // Synchronised copies reset to idle-high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], uart_data};
      rx_prev <= sync_q[1];
    end
  end

  assign rx_s = sync_q[1];

  always_comb begin
    bstate_d  = bstate;
    cnt_d     = cnt + 1'b1;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    par_bad_d = par_bad;
    stop_hit  = 1'b0;
    unique case (bstate)
      B_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) begin
          bstate_d  = B_START;
          par_bad_d = 1'b0;
        end
      end
      B_START: begin
        if (cnt == HALF_CNT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          bstate_d  = rx_s ? B_IDLE : B_BITS;
        end
      end
      B_BITS: begin
        if (cnt == LAST_CNT) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) bstate_d = (PARITY != 0) ? B_PAR : B_STOP;
        end
      end
      B_PAR: begin
        if (cnt == LAST_CNT) begin
          cnt_d     = '0;
          par_bad_d = (^{shreg, rx_s}) != (PARITY == 2);
          bstate_d  = B_STOP;
        end
      end
      B_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_d    = '0;
          stop_hit = 1'b1;
          bstate_d = B_IDLE;
        end
      end
      default: bstate_d = B_IDLE;
    endcase
  end

  assign frame_ok = rx_s && !par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      bstate    <= B_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      rx_strobe <= 1'b0;
      byte_err  <= 1'b0;
      rx_byte   <= '0;
    end else begin
      bstate    <= bstate_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_idx_d;
      shreg     <= shreg_d;
      par_bad   <= par_bad_d;
      rx_strobe <= stop_hit && frame_ok;
      byte_err  <= stop_hit && !frame_ok;
      if (stop_hit && frame_ok) rx_byte <= shreg;
    end
  end

  // A byte event beats a timeout landing in the same cycle.
  assign timed_out = (timer == TO_LAST);

  always_comb begin
    pstate_d  = pstate;
    start_pkt = 1'b0;
    take_data = 1'b0;
    commit    = 1'b0;
    abort     = 1'b0;
    unique case (pstate)
      HUNT: begin
        if (rx_strobe && rx_byte == SYNC_BYTE) begin
          pstate_d  = DATA;
          start_pkt = 1'b1;
        end
      end
      DATA: begin
        if (byte_err) begin
          abort    = 1'b1;
          pstate_d = HUNT;
        end else if (rx_strobe) begin
          take_data = 1'b1;
          if (par_idx == LAST_PAR && sub_idx == LAST_SUB) pstate_d = CSUM;
        end else if (timed_out) begin
          abort    = 1'b1;
          pstate_d = HUNT;
        end
      end
      CSUM: begin
        if (byte_err || (!rx_strobe && timed_out)) begin
          abort    = 1'b1;
          pstate_d = HUNT;
        end else if (rx_strobe) begin
          commit   = (rx_byte == sum);
          abort    = (rx_byte != sum);
          pstate_d = HUNT;
        end
      end
      default: pstate_d = HUNT;
    endcase
  end

  // Parameters arrive MSB byte first; shifting into a PAR_W register truncates the excess.
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate     <= HUNT;
      sum        <= '0;
      par_idx    <= '0;
      sub_idx    <= '0;
      timer      <= '0;
      conf_valid <= 1'b0;
      conf_err   <= 1'b0;
      par_out    <= {PAR_CNT{PAR_RST}};
      for (int k = 0; k < PAR_CNT; k++) shadow[k] <= '0;
    end else begin
      pstate     <= pstate_d;
      conf_valid <= commit;
      conf_err   <= abort;
      if (pstate_d == HUNT || start_pkt || rx_strobe || byte_err) timer <= '0;
      else timer <= timer + 1'b1;
      if (start_pkt) begin
        sum     <= '0;
        par_idx <= '0;
        sub_idx <= '0;
      end
      if (take_data) begin
        sum             <= sum + rx_byte;
        shadow[par_idx] <= PAR_W'({shadow[par_idx], rx_byte});
        if (sub_idx == LAST_SUB) begin
          sub_idx <= '0;
          par_idx <= par_idx + 1'b1;
        end else begin
          sub_idx <= sub_idx + 1'b1;
        end
      end
      if (commit) begin
        for (int k = 0; k < PAR_CNT; k++) par_out[k*PAR_W +: PAR_W] <= shadow[k];
      end
    end
  end

  assign state = pstate;

endmodule

// File: tb/tb_uart_conf_rx.sv
// Bench for uart_conf_rx: two instances (no parity / even parity) driven with directed and
// random frames, checked against a packet-level reference model of expected events.
module tb_uart_conf_rx;

  localparam int         CLK_HZ  = 1_000_000;
  localparam int         BAUD    = 62_500;
  localparam int         DIV     = 16;
  localparam int         PAR_CNT = 2;
  localparam int         PAR_W   = 12;
  localparam int         BYTES   = 2;
  localparam int         TO_CLKS = 20 * DIV;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line [2] = '{1'b1, 1'b1};

  logic [23:0] par_out_a    [2];
  logic        conf_valid_a [2];
  logic        conf_err_a   [2];
  logic [7:0]  rx_byte_a    [2];
  logic        rx_strobe_a  [2];
  logic [1:0]  state_a      [2];

  always #5 clk = ~clk;

  uart_conf_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .PAR_CNT(PAR_CNT), .PAR_W(PAR_W), .PARITY(0),
    .SYNC_BYTE(SYNC), .TIMEOUT_BITS(20), .PAR_RST(12'h000)
  ) dut0 (
    .clk(clk), .rst(rst), .uart_data(line[0]), .par_out(par_out_a[0]),
    .conf_valid(conf_valid_a[0]), .conf_err(conf_err_a[0]), .rx_byte(rx_byte_a[0]),
    .rx_strobe(rx_strobe_a[0]), .state(state_a[0])
  );

  uart_conf_rx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .PAR_CNT(PAR_CNT), .PAR_W(PAR_W), .PARITY(1),
    .SYNC_BYTE(SYNC), .TIMEOUT_BITS(20), .PAR_RST(12'h5A5)
  ) dut1 (
    .clk(clk), .rst(rst), .uart_data(line[1]), .par_out(par_out_a[1]),
    .conf_valid(conf_valid_a[1]), .conf_err(conf_err_a[1]), .rx_byte(rx_byte_a[1]),
    .rx_strobe(rx_strobe_a[1]), .state(state_a[1])
  );

  int checks = 0;
  int errors = 0;
  // Expected event stream per instance: [31:30] 1 = byte strobe, 2 = commit, 3 = error.
  logic [31:0] exp_q [2][$];
  logic [7:0]  pkt_q [2][$];
  bit          in_pkt [2] = '{1'b0, 1'b0};
  int          strobe_cnt [2] = '{0, 0};
  int          valid_cnt  [2] = '{0, 0};
  int          err_cnt    [2] = '{0, 0};
  logic        prev_strobe [2] = '{1'b0, 1'b0};
  logic [23:0] prev_par    [2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_byte(input int i, input bit good, input logic [7:0] b);
    logic [7:0]  s;
    logic [23:0] bank;
    logic [31:0] v;
    if (good) exp_q[i].push_back({2'd1, 22'd0, b});
    if (!in_pkt[i]) begin
      if (good && b == SYNC) begin
        in_pkt[i] = 1'b1;
        pkt_q[i].delete();
      end
    end else if (!good) begin
      exp_q[i].push_back({2'd3, 30'd0});
      in_pkt[i] = 1'b0;
    end else if (pkt_q[i].size() < PAR_CNT * BYTES) begin
      pkt_q[i].push_back(b);
    end else begin
      s = 8'd0;
      for (int k = 0; k < PAR_CNT * BYTES; k++) s = s + pkt_q[i][k];
      if (s == b) begin
        bank = '0;
        for (int p = 0; p < PAR_CNT; p++) begin
          v = 32'd0;
          for (int q = 0; q < BYTES; q++) v = (v << 8) | 32'(pkt_q[i][p*BYTES+q]);
          bank[p*PAR_W +: PAR_W] = v[PAR_W-1:0];
        end
        exp_q[i].push_back({2'd2, 6'd0, bank});
      end else begin
        exp_q[i].push_back({2'd3, 30'd0});
      end
      in_pkt[i] = 1'b0;
    end
  endtask

  task automatic model_timeout(input int i);
    if (in_pkt[i]) begin
      exp_q[i].push_back({2'd3, 30'd0});
      in_pkt[i] = 1'b0;
    end
  endtask

  task automatic hold_bit(input int i, input logic v, input int n);
    line[i] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int i, input logic [7:0] b, input bit bad_par,
                               input bit bad_stop, input int gap);
    bit good;
    good = !bad_stop && !(i == 1 && bad_par);
    model_byte(i, good, b);
    hold_bit(i, 1'b0, DIV);
    for (int k = 0; k < 8; k++) hold_bit(i, b[k], DIV);
    if (i == 1) hold_bit(i, (^b) ^ bad_par, DIV);
    hold_bit(i, !bad_stop, DIV);
    if (bad_stop) hold_bit(i, 1'b1, DIV);
    line[i] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bytes(input int i, input logic [63:0] data, input int n, input int gap);
    for (int k = 0; k < n; k++) applyStimulus(i, data[8*(n-1-k) +: 8], 1'b0, 1'b0, gap);
  endtask

  task automatic pop_check(input int i, input logic [1:0] typ, input logic [23:0] data);
    logic [31:0] e;
    if (exp_q[i].size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d_unexpected_event: got type %0d data 0x%0h, expected none", i, typ, data);
    end else begin
      e = exp_q[i].pop_front();
      checkOutput($sformatf("dut%0d_event_type", i), 32'(typ), 32'(e[31:30]));
      if (typ == e[31:30] && typ != 2'd3)
        checkOutput($sformatf("dut%0d_event_data", i), 32'(data), 32'(e[23:0]));
    end
  endtask

  // Every DUT pulse must match the next modelled event, in order.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (rx_strobe_a[i]) begin
          strobe_cnt[i]++;
          pop_check(i, 2'd1, {16'd0, rx_byte_a[i]});
        end
        if (conf_valid_a[i]) begin
          valid_cnt[i]++;
          pop_check(i, 2'd2, par_out_a[i]);
          checkOutput($sformatf("dut%0d_valid_after_strobe", i), 32'(prev_strobe[i]), 32'd1);
        end
        if (conf_err_a[i]) begin
          err_cnt[i]++;
          pop_check(i, 2'd3, 24'd0);
        end
        checkOutput($sformatf("dut%0d_valid_err_exclusive", i),
                    32'(conf_valid_a[i] & conf_err_a[i]), 32'd0);
        if (!conf_valid_a[i])
          checkOutput($sformatf("dut%0d_par_stable", i), 32'(par_out_a[i]), 32'(prev_par[i]));
      end
      prev_strobe[i] = rx_strobe_a[i];
      prev_par[i]    = par_out_a[i];
    end
  end

  task automatic settle();
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic check_pending(input int i);
    checkOutput($sformatf("dut%0d_pending_events", i), 32'(exp_q[i].size()), 32'd0);
  endtask

  task automatic random_packet(input int i);
    logic [7:0] pk [6];
    logic [7:0] s;
    int kind, bad_pos, last, gap;
    bit use_par;
    kind    = $urandom_range(0, 5);
    gap     = $urandom_range(0, DIV);
    use_par = (i == 1) && ($urandom_range(0, 1) == 1);
    if (kind == 3) begin
      for (int k = 0; k < 2; k++) applyStimulus(i, 8'($urandom), 1'b0, 1'b0, gap);
      return;
    end
    pk[0] = SYNC;
    s = 8'd0;
    for (int k = 1; k < 5; k++) begin
      pk[k] = 8'($urandom);
      s = s + pk[k];
    end
    pk[5] = (kind == 1) ? s + 8'd1 + 8'($urandom_range(0, 254)) : s;
    bad_pos = (kind == 2) ? $urandom_range(1, 5) : 99;
    last    = (kind == 4) ? $urandom_range(0, 4) : 5;
    for (int k = 0; k <= last; k++)
      applyStimulus(i, pk[k], (k == bad_pos) && use_par, (k == bad_pos) && !use_par, gap);
    if (kind == 4) begin
      model_timeout(i);
      repeat (TO_CLKS + 10) @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("dut0_reset_par_out", 32'(par_out_a[0]), 32'h000000);
    checkOutput("dut1_reset_par_out", 32'(par_out_a[1]), 32'h5A55A5);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dut%0d_reset_state", i), 32'(state_a[i]), 32'd0);
      checkOutput($sformatf("dut%0d_reset_rx_byte", i), 32'(rx_byte_a[i]), 32'd0);
      checkOutput($sformatf("dut%0d_reset_pulses", i),
                  32'({rx_strobe_a[i], conf_valid_a[i], conf_err_a[i]}), 32'd0);
    end
    repeat (4) @(negedge clk);

    send_bytes(0, 64'hA5_01_23_0F_FF_32, 6, 2);
    settle();
    checkOutput("good_par_out", 32'(par_out_a[0]), 32'hFFF123);
    checkOutput("good_strobes", 32'(strobe_cnt[0]), 32'd6);
    checkOutput("good_valid_count", 32'(valid_cnt[0]), 32'd1);
    checkOutput("good_err_count", 32'(err_cnt[0]), 32'd0);
    checkOutput("good_state", 32'(state_a[0]), 32'd0);

    send_bytes(0, 64'hA5_01_23_0F_FF_33, 6, 2);
    settle();
    checkOutput("badsum_par_out", 32'(par_out_a[0]), 32'hFFF123);
    checkOutput("badsum_valid_count", 32'(valid_cnt[0]), 32'd1);
    checkOutput("badsum_err_count", 32'(err_cnt[0]), 32'd1);

    send_bytes(1, 64'hA5_01, 2, 2);
    applyStimulus(1, 8'h07, 1'b1, 1'b0, 2);
    settle();
    checkOutput("parity_strobes", 32'(strobe_cnt[1]), 32'd2);
    checkOutput("parity_err_count", 32'(err_cnt[1]), 32'd1);
    checkOutput("parity_state", 32'(state_a[1]), 32'd0);
    send_bytes(1, 64'hA5_07_00_10_20_37, 6, 2);
    settle();
    checkOutput("parity_good_par_out", 32'(par_out_a[1]), 32'h020700);
    checkOutput("parity_good_valid", 32'(valid_cnt[1]), 32'd1);

    hold_bit(0, 1'b0, DIV / 4);
    hold_bit(0, 1'b1, 3 * DIV);
    checkOutput("glitch_strobes", 32'(strobe_cnt[0]), 32'd12);
    checkOutput("glitch_state", 32'(state_a[0]), 32'd0);
    applyStimulus(0, 8'h5A, 1'b0, 1'b1, 2);
    settle();
    checkOutput("framing_strobes", 32'(strobe_cnt[0]), 32'd12);
    checkOutput("framing_err_count", 32'(err_cnt[0]), 32'd1);

    send_bytes(0, 64'hA5_01, 2, 0);
    checkOutput("timeout_state_data", 32'(state_a[0]), 32'd1);
    model_timeout(0);
    repeat (TO_CLKS + 10) @(negedge clk);
    checkOutput("timeout_err_count", 32'(err_cnt[0]), 32'd2);
    checkOutput("timeout_state", 32'(state_a[0]), 32'd0);
    send_bytes(0, 64'hA5_12_34_56_78_14, 6, 2);
    settle();
    checkOutput("after_timeout_par_out", 32'(par_out_a[0]), 32'h678234);
    checkOutput("after_timeout_valid", 32'(valid_cnt[0]), 32'd2);
    check_pending(0);
    check_pending(1);

    for (int n = 0; n < 24; n++) random_packet(n % 2);
    model_timeout(0);
    model_timeout(1);
    repeat (TO_CLKS + 10 + 2 * DIV) @(negedge clk);
    check_pending(0);
    check_pending(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
